// File: rtl/pc_unit.sv
// Program counter with trap/return, redirect handling and a circular return-address stack.
// Misaligned redirects are converted into traps and flagged for one cycle.
module pc_unit #(
  parameter int unsigned     XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_ADDR = '0,
  parameter logic [XLEN-1:0] TRAP_VEC   = XLEN'(32'h100),
  parameter int unsigned     RAS_DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         stall,
  input  logic                         trap_en,
  input  logic                         mret_en,
  input  logic                         branch_en,
  input  logic [XLEN-1:0]              branch_addr,
  input  logic                         ras_push,
  input  logic                         ras_pop,
  output logic [XLEN-1:0]              pc_cnt,
  output logic [XLEN-1:0]              epc,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         misalign
);

  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic [XLEN-1:0] ras_q [RAS_DEPTH];
  logic [XLEN-1:0] ras_d [RAS_DEPTH];
  logic [PW-1:0]   top_q, top_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            misalign_q, misalign_d;

  logic [XLEN-1:0] pc_plus4;
  logic [PW-1:0]   top_idx;

  always_comb begin
    pc_plus4   = pc_q + XLEN'(4);
    top_idx    = top_q - PW'(1);
    pc_d       = pc_q;
    epc_d      = epc_q;
    ras_d      = ras_q;
    top_d      = top_q;
    cnt_d      = cnt_q;
    misalign_d = 1'b0;

    if (trap_en) begin
      pc_d  = TRAP_VEC;
      epc_d = pc_q;
    end else if (mret_en) begin
      pc_d = epc_q;
    end else if (branch_en) begin
      if (branch_addr[1:0] == 2'b00) begin
        pc_d = branch_addr;
      end else begin
        pc_d       = TRAP_VEC;
        epc_d      = pc_q;
        misalign_d = 1'b1;
      end
    end else if (!stall) begin
      pc_d = pc_plus4;
      // top_q is the next write slot; when full it also marks the oldest entry,
      // so a saturated push overwrites it without extra bookkeeping.
      if (ras_pop && (cnt_q != '0)) begin
        pc_d = ras_q[top_idx];
        if (ras_push) begin
          ras_d[top_idx] = pc_plus4;
        end else begin
          top_d = top_idx;
          cnt_d = cnt_q - CW'(1);
        end
      end else if (ras_push) begin
        ras_d[top_q] = pc_plus4;
        top_d        = top_q + PW'(1);
        if (cnt_q != CW'(RAS_DEPTH)) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_q       <= RESET_ADDR;
      epc_q      <= '0;
      top_q      <= '0;
      cnt_q      <= '0;
      misalign_q <= 1'b0;
      for (int unsigned i = 0; i < RAS_DEPTH; i++) begin
        ras_q[i] <= '0;
      end
    end else begin
      pc_q       <= pc_d;
      epc_q      <= epc_d;
      top_q      <= top_d;
      cnt_q      <= cnt_d;
      misalign_q <= misalign_d;
      ras_q      <= ras_d;
    end
  end

  assign pc_cnt    = pc_q;
  assign epc       = epc_q;
  assign ras_count = cnt_q;
  assign misalign  = misalign_q;

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboarded bench for pc_unit: the driver pushes model expectations, a monitor pops and compares.
module tb_pc_unit;

  localparam logic [31:0] TV    = 32'h100;
  localparam int          DEPTH = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        stall = 0, trap_en = 0, mret_en = 0, branch_en = 0, ras_push = 0, ras_pop = 0;
  logic [31:0] branch_addr = '0;
  logic [31:0] pc_cnt, epc;
  logic [2:0]  ras_count;
  logic        misalign;

  logic        b8_en = 0;
  logic [7:0]  b8_addr = '0;
  logic [7:0]  pc8, epc8;
  logic [1:0]  cnt8;
  logic        mis8;

  always #5 clk = ~clk;

  pc_unit #(.XLEN(32), .RESET_ADDR(32'h0), .TRAP_VEC(32'h100), .RAS_DEPTH(4)) dut (
    .clk(clk), .rstn(rstn), .stall(stall), .trap_en(trap_en), .mret_en(mret_en),
    .branch_en(branch_en), .branch_addr(branch_addr), .ras_push(ras_push), .ras_pop(ras_pop),
    .pc_cnt(pc_cnt), .epc(epc), .ras_count(ras_count), .misalign(misalign));

  pc_unit #(.XLEN(8), .RESET_ADDR(8'h0), .TRAP_VEC(8'h40), .RAS_DEPTH(2)) dut8 (
    .clk(clk), .rstn(rstn), .stall(1'b0), .trap_en(1'b0), .mret_en(1'b0),
    .branch_en(b8_en), .branch_addr(b8_addr), .ras_push(1'b0), .ras_pop(1'b0),
    .pc_cnt(pc8), .epc(epc8), .ras_count(cnt8), .misalign(mis8));

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] epc;
    logic [2:0]  cnt;
    logic        mis;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] exp8_q[$];
  int         checks = 0;
  int         errors = 0;
  int         step = 0;

  // Reference model: architectural PC/EPC and the return stack as a plain queue.
  logic [31:0] m_pc, m_epc;
  logic [31:0] m_ras[$];

  task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", nm, id, act, req);
    end
  endtask

  task automatic model_reset();
    m_pc  = 32'h0;
    m_epc = 32'h0;
    m_ras.delete();
  endtask

  task automatic model_step(input bit st, input bit tr, input bit mr, input bit br,
                            input logic [31:0] ba, input bit pu, input bit po);
    exp_t        e;
    logic [31:0] p4;
    bit          mis;
    mis = 0;
    p4  = m_pc + 32'd4;
    if (tr) begin
      m_epc = m_pc; m_pc = TV;
    end else if (mr) begin
      m_pc = m_epc;
    end else if (br) begin
      if (ba[1:0] == 2'b00) m_pc = ba;
      else begin m_epc = m_pc; m_pc = TV; mis = 1; end
    end else if (!st) begin
      if (po && m_ras.size() > 0) begin
        m_pc = m_ras[$];
        void'(m_ras.pop_back());
        if (pu) m_ras.push_back(p4);
      end else begin
        m_pc = p4;
        if (pu) begin
          m_ras.push_back(p4);
          if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
        end
      end
    end
    e.pc  = m_pc;
    e.epc = m_epc;
    e.cnt = 3'(m_ras.size());
    e.mis = mis;
    exp_q.push_back(e);
  endtask

  task automatic drive(input bit st, input bit tr, input bit mr, input bit br,
                       input logic [31:0] ba, input bit pu, input bit po);
    @(negedge clk);
    stall = st; trap_en = tr; mret_en = mr; branch_en = br;
    branch_addr = ba; ras_push = pu; ras_pop = po;
    model_step(st, tr, mr, br, ba, pu, po);
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 32'h0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    stall = 0; trap_en = 0; mret_en = 0; branch_en = 0; ras_push = 0; ras_pop = 0; b8_en = 0;
    #1;
    chk("reset_pc", -1, pc_cnt, 32'h0);
    chk("reset_epc", -1, epc, 32'h0);
    chk("reset_cnt", -1, 32'(ras_count), 32'h0);
    chk("reset_mis", -1, 32'(misalign), 32'h0);
    chk("reset_pc8", -1, 32'(pc8), 32'h0);
    model_reset();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    model_step(0, 0, 0, 0, 32'h0, 0, 0);
  endtask

  // Monitor: the DUT presents a new state after every rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pc_cnt", step, pc_cnt, e.pc);
        chk("epc", step, epc, e.epc);
        chk("ras_count", step, 32'(ras_count), 32'(e.cnt));
        chk("misalign", step, 32'(misalign), 32'(e.mis));
        step++;
      end
      if (exp8_q.size() > 0) begin
        chk("pc8", step, 32'(pc8), 32'(exp8_q.pop_front()));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] ba;
    bit st, tr, mr, br, pu, po;
    model_reset();
    do_reset();
    repeat (3) idle();

    // Redirect beats stall; stall alone holds
    drive(1, 0, 0, 1, 32'h200, 0, 0);
    drive(1, 0, 0, 0, 32'h0, 1, 1);
    drive(1, 0, 0, 0, 32'h0, 0, 0);

    // Misaligned branch becomes a trap, then return
    drive(0, 0, 0, 1, 32'h40, 0, 0);
    drive(0, 0, 0, 1, 32'h202, 0, 0);
    idle();
    drive(0, 0, 1, 0, 32'h0, 0, 0);

    // Overfill the stack then drain it past empty
    for (int i = 1; i <= 5; i++) begin
      drive(0, 0, 0, 1, 32'(i * 16), 0, 0);
      drive(0, 0, 0, 0, 32'h0, 1, 0);
    end
    for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, 32'h0, 0, 1);

    // Trap wins over branch and pop; RAS untouched
    drive(0, 0, 0, 0, 32'h0, 1, 0);
    drive(0, 0, 0, 1, 32'h300, 0, 1);
    drive(0, 1, 0, 1, 32'h300, 0, 1);
    // Simultaneous push/pop: non-empty swaps top, then empty pushes only
    drive(0, 0, 0, 0, 32'h0, 1, 1);
    drive(0, 0, 0, 0, 32'h0, 0, 1);
    drive(0, 0, 0, 0, 32'h0, 1, 1);

    // 8-bit instance wraps 0xFC -> 0x00
    idle();
    b8_en = 1; b8_addr = 8'hFC; exp8_q.push_back(8'hFC);
    idle();
    b8_en = 0; exp8_q.push_back(8'h00);
    idle();
    exp8_q.push_back(8'h04);

    for (int n = 0; n < 400; n++) begin
      st = ($urandom_range(0, 99) < 15);
      tr = ($urandom_range(0, 99) < 4);
      mr = ($urandom_range(0, 99) < 5);
      br = ($urandom_range(0, 99) < 10);
      pu = ($urandom_range(0, 99) < 35);
      po = ($urandom_range(0, 99) < 35);
      ba = $urandom & 32'h0000_0FFC;
      if ($urandom_range(0, 7) == 0) ba = ba | 32'($urandom_range(1, 3));
      drive(st, tr, mr, br, ba, pu, po);
      if (n == 200) begin
        @(negedge clk);
        do_reset();
      end
    end

    idle();
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || exp8_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size() + exp8_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
